// File: rtl/ps2_direction_decoder_if.sv
// PS/2 byte stream in, per-player held directions and pause level out.
// The decoder is the slave; the bench or the PS/2/skeleton glue is the master.
interface ps2_direction_decoder_if;
   logic       ps2_key_pressed;
   logic [7:0] ps2_out;
   logic       upSig;
   logic       rightSig;
   logic       downSig;
   logic       leftSig;
   logic       upSig2;
   logic       rightSig2;
   logic       downSig2;
   logic       leftSig2;
   logic       pauseButton;

   modport master (
      output ps2_key_pressed, ps2_out,
      input  upSig, rightSig, downSig, leftSig,
      input  upSig2, rightSig2, downSig2, leftSig2, pauseButton
   );

   modport slave (
      input  ps2_key_pressed, ps2_out,
      output upSig, rightSig, downSig, leftSig,
      output upSig2, rightSig2, downSig2, leftSig2, pauseButton
   );
endinterface

// File: rtl/ps2_direction_decoder.sv
// Scan-code set 2 make/break tracker producing held-direction and pause levels.
// Define LAST_KEY_WINS_EN to make each player's outputs one-hot on the last-pressed key.
module ps2_direction_decoder #(
   parameter int unsigned PREFIX_TIMEOUT = 1_000_000
) (
   input  logic                   clock,
   input  logic                   reset,
   ps2_direction_decoder_if.slave ps2
);
   localparam int unsigned CNT_W  = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned KEY_N  = 8;

   localparam logic [BYTE_W-1:0] CODE_BREAK = 8'hF0;
   localparam logic [BYTE_W-1:0] CODE_EXT   = 8'hE0;
   localparam logic [BYTE_W-1:0] CODE_P     = 8'h4D;
   localparam logic [BYTE_W-1:0] CODE_ESC   = 8'h76;

   typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_EXT, ST_EXT_BREAK} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [KEY_N-1:0]   held_q, held_d;
   logic               p_held_q, p_held_d;
   logic               pause_q, pause_d;
   logic               is_make, is_break;
   logic               ext_ctx;
   logic               key_hit;
   logic [2:0]         key_idx;
   logic [BYTE_W-1:0]  rx_byte;
   logic [3:0]         dir0, dir1;
`ifdef LAST_KEY_WINS_EN
   logic [1:0][2:0]    last_q, last_d;
`endif

   assign rx_byte = ps2.ps2_out;
   assign ext_ctx = (state_q == ST_EXT) || (state_q == ST_EXT_BREAK);

   // Direction key lookup; plain and extended tables are disjoint by context
   always_comb begin
      key_hit = 1'b1;
      key_idx = 3'd0;
      if (ext_ctx) begin
         case (rx_byte)
            8'h75:   key_idx = 3'd4;
            8'h74:   key_idx = 3'd5;
            8'h72:   key_idx = 3'd6;
            8'h6B:   key_idx = 3'd7;
            default: key_hit = 1'b0;
         endcase
      end else begin
         case (rx_byte)
            8'h1D:   key_idx = 3'd0;
            8'h23:   key_idx = 3'd1;
            8'h1B:   key_idx = 3'd2;
            8'h1C:   key_idx = 3'd3;
            default: key_hit = 1'b0;
         endcase
      end
   end

   // Prefix FSM, timeout counter and key state update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      held_d   = held_q;
      p_held_d = p_held_q;
      pause_d  = pause_q;
      is_make  = 1'b0;
      is_break = 1'b0;
`ifdef LAST_KEY_WINS_EN
      last_d   = last_q;
`endif
      if (ps2.ps2_key_pressed) begin
         cnt_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (rx_byte == CODE_BREAK)    state_d = ST_BREAK;
               else if (rx_byte == CODE_EXT) state_d = ST_EXT;
               else                          is_make = 1'b1;
            end
            ST_BREAK: begin
               state_d  = ST_IDLE;
               is_break = (rx_byte != CODE_EXT);
            end
            ST_EXT: begin
               if (rx_byte == CODE_BREAK) state_d = ST_EXT_BREAK;
               else if (rx_byte != CODE_EXT) begin
                  is_make = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            default: begin
               is_break = 1'b1;
               state_d  = ST_IDLE;
            end
         endcase
      end else if (state_q != ST_IDLE) begin
         // A stale prefix is dropped once the counter would reach the limit
         if (cnt_q == CNT_W'(PREFIX_TIMEOUT - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if ((is_make || is_break) && key_hit) begin
         held_d[key_idx] = is_make;
`ifdef LAST_KEY_WINS_EN
         if (is_make) last_d[key_idx[2]] = {1'b0, key_idx[1:0]} + 3'd1;
`endif
      end

      if (!ext_ctx && rx_byte == CODE_P) begin
         if (is_make && !p_held_q) begin
            pause_d  = ~pause_q;
            p_held_d = 1'b1;
         end else if (is_break) begin
            p_held_d = 1'b0;
         end
      end

      if (is_make && !ext_ctx && rx_byte == CODE_ESC) begin
         held_d = '0;
`ifdef LAST_KEY_WINS_EN
         last_d = '0;
`endif
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         held_q   <= '0;
         p_held_q <= 1'b0;
         pause_q  <= 1'b0;
`ifdef LAST_KEY_WINS_EN
         last_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         held_q   <= held_d;
         p_held_q <= p_held_d;
         pause_q  <= pause_d;
`ifdef LAST_KEY_WINS_EN
         last_q   <= last_d;
`endif
      end
   end

`ifdef LAST_KEY_WINS_EN
   // Last-pressed key while held, else highest-priority held key (up > right > down > left)
   function automatic logic [3:0] pick(input logic [3:0] held, input logic [2:0] last);
      logic [1:0] li;
      pick = '0;
      li   = 2'(last - 3'd1);
      if (last != 3'd0 && held[li]) pick[li] = 1'b1;
      else if (held[0])              pick[0] = 1'b1;
      else if (held[1])              pick[1] = 1'b1;
      else if (held[2])              pick[2] = 1'b1;
      else if (held[3])              pick[3] = 1'b1;
   endfunction

   always_comb begin
      dir0 = pick(held_q[3:0], last_q[0]);
      dir1 = pick(held_q[7:4], last_q[1]);
   end
`else
   always_comb begin
      dir0 = held_q[3:0];
      dir1 = held_q[7:4];
   end
`endif

   assign ps2.upSig       = dir0[0];
   assign ps2.rightSig    = dir0[1];
   assign ps2.downSig     = dir0[2];
   assign ps2.leftSig     = dir0[3];
   assign ps2.upSig2      = dir1[0];
   assign ps2.rightSig2   = dir1[1];
   assign ps2.downSig2    = dir1[2];
   assign ps2.leftSig2    = dir1[3];
   assign ps2.pauseButton = pause_q;
endmodule

// File: doc/ps2_direction_decoder.md
# ps2_direction_decoder

Converts the PS/2 keyboard byte stream (`ps2_key_pressed` strobe plus `ps2_out` scan-code byte) into the per-player held-direction levels and pause level that the processor skeleton consumes. It sits between the PS/2 controller and `proc_skeleton`, and is the producer side of that skeleton's input interface. The skeleton returns a direction code (1 = up, 2 = right, 3 = down, 4 = left) only when exactly one direction is asserted for a player. This block tracks key make/break state, so outputs stay high while a key is held.

## Interface
- `PREFIX_TIMEOUT`, default 1_000_000: cycles a prefix state may wait for its next byte before it is discarded.
- `clock` in 1: the only clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low. Clears all state.
- `ps2_key_pressed` in 1: byte-valid strobe. Each cycle it is high delivers one byte. The PS/2 controller guarantees single-cycle pulses.
- `ps2_out` in 8: scan-code byte (set 2), valid when `ps2_key_pressed` is high.
- `upSig`, `rightSig`, `downSig`, `leftSig` out 1 each: player 0 directions, driven by W/D/S/A.
- `upSig2`, `rightSig2`, `downSig2`, `leftSig2` out 1 each: player 1 directions, driven by the arrow keys.
- `pauseButton` out 1: pause level, toggled by the P key.

## Operation
- Prefix FSM states: IDLE, BREAK (after F0), EXT (after E0), EXT_BREAK (after E0 F0). Bytes are accepted only on cycles where `ps2_key_pressed` is high.
- IDLE transitions:
  - F0 goes to BREAK.
  - E0 goes to EXT.
  - Any other byte is a make of a plain code; state stays IDLE.
- BREAK transitions:
  - E0 is discarded and the FSM returns to IDLE.
  - Any other byte is a break of a plain code, then IDLE.
- EXT transitions:
  - F0 goes to EXT_BREAK.
  - E0 stays in EXT.
  - Any other byte is a make of an extended code, then IDLE.
- EXT_BREAK transitions:
  - Any byte is a break of an extended code, then IDLE.
- Plain codes:
  - 1D = P0 up, 23 = P0 right, 1B = P0 down, 1C = P0 left.
  - 4D = P.
  - 76 = Esc.
- Extended codes:
  - 75 = P1 up, 74 = P1 right, 72 = P1 down, 6B = P1 left.
- Cross-table codes have no effect: plain 75/74/72/6B (keypad) and extended 1D/23/1B/1C. All unlisted codes are also ignored, but the FSM still returns to IDLE.
- Make sets the key's held bit; break clears it. Typematic repeat makes are idempotent.
- P handling: a make while P is not held toggles `pauseButton` and sets `p_held`. A make while `p_held` is set does not toggle. A break clears `p_held`.
- Esc make clears all eight direction held bits and both last-key registers. `pauseButton` is unaffected.
- Prefix timeout: a counter runs in BREAK, EXT and EXT_BREAK and clears on each accepted byte. When it reaches `PREFIX_TIMEOUT`, the FSM goes to IDLE and the partial sequence is dropped.
- The counter width is 32 bits and never wraps, because it is reset at `PREFIX_TIMEOUT`.

## Timing
- Latency: a byte strobed at rising edge N updates the held bits, FSM, `pauseButton` and outputs at edge N. Outputs are valid before edge N+1.
- All outputs are registered, or are combinational only from registers; there is no combinational path from `ps2_out`.
- Reset values: all direction outputs 0, `pauseButton` 0, FSM in IDLE, counter 0, `p_held` 0, last-key registers set to none.
- Reset asserted mid-sequence (for example after E0) returns the FSM to IDLE immediately. The next byte is decoded as plain.
- A strobe on the same edge as timeout expiry: the byte wins. It is decoded in the current prefix state.

## Configuration
- `LAST_KEY_WINS_EN` defined:
  - Each player keeps a 3-bit last-pressed direction register, updated on every direction make.
  - That player's outputs are one-hot on the last-pressed key while it is held.
  - On break of the last-pressed key, output falls back to the highest-priority key still held (up > right > down > left), or to none.
  - This ensures the skeleton always sees a single direction.
- `LAST_KEY_WINS_EN` undefined: each output is the raw held bit. Multiple simultaneous directions may be high, and the last-key registers are not built.

## Test plan
- Reset, then 1D strobed: `upSig` = 1 at the next edge. Then F0, 1D: `upSig` = 0. Other outputs stay 0 throughout.
- E0 74 strobed: `rightSig2` = 1. Then plain 74: no change. Then E0 F0 74: `rightSig2` = 0.
- Plain 75: `upSig2` stays 0.
- 4D, 4D, 4D (repeats), then F0 4D, then 4D: `pauseButton` goes 0→1 after the first make, holds 1 through the repeats, and goes to 0 after the second press.
- E0, then idle for `PREFIX_TIMEOUT` cycles, then 74: decoded as plain 74, so `rightSig2` = 0.
- With `LAST_KEY_WINS_EN`: 1D then 23 gives `rightSig` = 1 and `upSig` = 0. Then F0 23 gives `upSig` = 1. Then 76 (Esc) gives all direction outputs 0, with `pauseButton` unchanged.
- Without `LAST_KEY_WINS_EN`: the same 1D then 23 sequence gives `upSig` = `rightSig` = 1.
